// File: rtl/sipo_deser_pkg.sv
// Shared definitions for the piso/sipo serial link: bit-order selectors and
// the counter width derived from the word width.
package sipo_deser_pkg;

  localparam bit BIT_ORDER_LSB = 1'b0;
  localparam bit BIT_ORDER_MSB = 1'b1;

  // Width of a counter holding 0..width-1 (never narrower than one bit).
  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/sipo_shift_core.sv
// Serial-to-parallel shift register with bit counter and start-of-frame
// realignment. Presents the word including the bit sampled this cycle.
module sipo_shift_core
  import sipo_deser_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = BIT_ORDER_MSB
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        serial_in,
  input  logic                        bit_valid,
  input  logic                        sof,
  output logic [WIDTH-1:0]            word,
  output logic                        word_done,
  output logic [cnt_width(WIDTH)-1:0] bit_cnt
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] base;

  // Next shift value; sof discards the partial word before the new bit enters.
  always_comb begin
    base = sof ? '0 : sreg;
    if (MSB_FIRST == BIT_ORDER_MSB) begin
      word = {base[WIDTH-2:0], serial_in};
    end else begin
      word = {serial_in, base[WIDTH-1:1]};
    end
    word_done = bit_valid && !sof && (bit_cnt == CNT_LAST);
  end

  // Shift register: shift on valid bits, clear on a bare sof.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sreg <= '0;
    end else if (bit_valid) begin
      sreg <= word;
    end else if (sof) begin
      sreg <= '0;
    end
  end

  // Bit counter: sof realigns to 0 or 1, completion wraps to 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt <= '0;
    end else if (sof) begin
      bit_cnt <= bit_valid ? CNT_W'(1) : '0;
    end else if (word_done) begin
      bit_cnt <= '0;
    end else if (bit_valid) begin
      bit_cnt <= bit_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/sipo_deser.sv
// Serial deserializer: assembles WIDTH-bit words and offers them on a
// valid/ready interface through a single holding register, flagging
// dropped words with a sticky overrun bit.
module sipo_deser
  import sipo_deser_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = BIT_ORDER_MSB
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        serial_in,
  input  logic                        bit_valid,
  input  logic                        sof,
  input  logic                        data_ready,
  input  logic                        clr_ovr,
  output logic [WIDTH-1:0]            data_out,
  output logic                        data_valid,
  output logic                        overrun,
  output logic [cnt_width(WIDTH)-1:0] bit_cnt
);

  logic [WIDTH-1:0] word;
  logic             word_done;
  logic             load;
  logic             drop;

  sipo_shift_core #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .serial_in (serial_in),
    .bit_valid (bit_valid),
    .sof       (sof),
    .word      (word),
    .word_done (word_done),
    .bit_cnt   (bit_cnt)
  );

  // A completed word loads when the holding register is empty or being drained.
  always_comb begin
    load = word_done && (!data_valid || data_ready);
    drop = word_done && data_valid && !data_ready;
  end

  // Holding register and valid flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_out   <= '0;
      data_valid <= 1'b0;
    end else if (load) begin
      data_out   <= word;
      data_valid <= 1'b1;
    end else if (data_valid && data_ready) begin
      data_valid <= 1'b0;
    end
  end

  // Sticky overrun; a drop on the same edge beats the clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end else if (clr_ovr) begin
      overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sipo_deser.sv
// Self-checking bench for sipo_deser: directed scenarios plus randomized
// traffic against a queue-based reference model, MSB- and LSB-first.
module tb_sipo_deser;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         serial_in = 1'b0;
  logic         bit_valid = 1'b0;
  logic         sof = 1'b0;
  logic         data_ready = 1'b0;
  logic         clr_ovr = 1'b0;

  logic [W-1:0] dout_m, dout_l;
  logic         dval_m, dval_l, ovr_m, ovr_l;
  logic [1:0]   cnt_m, cnt_l;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit         bits[$];
  logic [W-1:0] exp_out_m, exp_out_l;
  logic       exp_val, exp_ovr;

  always #5 clk = ~clk;

  sipo_deser #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .serial_in(serial_in), .bit_valid(bit_valid),
    .sof(sof), .data_ready(data_ready), .clr_ovr(clr_ovr),
    .data_out(dout_m), .data_valid(dval_m), .overrun(ovr_m), .bit_cnt(cnt_m)
  );

  sipo_deser #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .serial_in(serial_in), .bit_valid(bit_valid),
    .sof(sof), .data_ready(data_ready), .clr_ovr(clr_ovr),
    .data_out(dout_l), .data_valid(dval_l), .overrun(ovr_l), .bit_cnt(cnt_l)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    bits.delete();
    exp_out_m = '0;
    exp_out_l = '0;
    exp_val   = 1'b0;
    exp_ovr   = 1'b0;
  endtask

  // Apply the current inputs to the model as one clock edge.
  task automatic model_step();
    logic         done;
    logic         dropped;
    logic [W-1:0] w_m, w_l;
    done = 1'b0;
    dropped = 1'b0;
    w_m = '0;
    w_l = '0;
    if (sof) bits.delete();
    if (bit_valid) begin
      bits.push_back(serial_in);
      if (bits.size() == W) begin
        done = 1'b1;
        for (int i = 0; i < W; i++) begin
          w_m[W-1-i] = bits[i];
          w_l[i]     = bits[i];
        end
        bits.delete();
      end
    end
    if (done) begin
      if (!exp_val || data_ready) begin
        exp_out_m = w_m;
        exp_out_l = w_l;
        exp_val   = 1'b1;
      end else begin
        dropped = 1'b1;
      end
    end else if (exp_val && data_ready) begin
      exp_val = 1'b0;
    end
    if (dropped) exp_ovr = 1'b1;
    else if (clr_ovr) exp_ovr = 1'b0;
  endtask

  task automatic compare_all();
    check_eq("dout_m", 32'(dout_m), 32'(exp_out_m));
    check_eq("dout_l", 32'(dout_l), 32'(exp_out_l));
    check_eq("dval_m", 32'(dval_m), 32'(exp_val));
    check_eq("dval_l", 32'(dval_l), 32'(exp_val));
    check_eq("ovr_m",  32'(ovr_m),  32'(exp_ovr));
    check_eq("ovr_l",  32'(ovr_l),  32'(exp_ovr));
    check_eq("cnt_m",  32'(cnt_m),  32'(bits.size()));
    check_eq("cnt_l",  32'(cnt_l),  32'(bits.size()));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic drive(input logic b, input logic v, input logic s);
    serial_in = b;
    bit_valid = v;
    sof       = s;
    tick();
    bit_valid = 1'b0;
    sof       = 1'b0;
  endtask

  task automatic send_word(input logic [3:0] w);
    for (int i = W - 1; i >= 0; i--) drive(w[i], 1'b1, 1'b0);
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once.
  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    #1;
    check_eq("rst_dout", 32'(dout_m), 32'h0);
    check_eq("rst_dval", 32'(dval_m), 32'h0);
    check_eq("rst_ovr",  32'(ovr_m),  32'h0);
    check_eq("rst_cnt",  32'(cnt_m),  32'h0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    do_reset();

    // 1: all-ones word, valid pulses for one cycle with ready high
    data_ready = 1'b1;
    send_word(4'hF);
    check_eq("t1_dout", 32'(dout_m), 32'hF);
    check_eq("t1_dval", 32'(dval_m), 32'h1);
    check_eq("t1_ovr",  32'(ovr_m),  32'h0);
    drive(1'b0, 1'b0, 1'b0);
    check_eq("t1_pulse", 32'(dval_m), 32'h0);

    // 2: 0,1,0,1 -> 5 MSB-first, A LSB-first
    do_reset();
    data_ready = 1'b1;
    send_word(4'h5);
    check_eq("t2_msb", 32'(dout_m), 32'h5);
    check_eq("t2_lsb", 32'(dout_l), 32'hA);

    // 3: stalled consumer drops the second word, then clear
    do_reset();
    data_ready = 1'b0;
    send_word(4'h5);
    send_word(4'h3);
    check_eq("t3_dout", 32'(dout_m), 32'h5);
    check_eq("t3_dval", 32'(dval_m), 32'h1);
    check_eq("t3_ovr",  32'(ovr_m),  32'h1);
    clr_ovr = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    clr_ovr = 1'b0;
    check_eq("t3_clr", 32'(ovr_m), 32'h0);

    // 4: sof discards a partial word
    do_reset();
    data_ready = 1'b1;
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b1);
    check_eq("t4_cnt", 32'(cnt_m), 32'h1);
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    check_eq("t4_dout", 32'(dout_m), 32'hC);
    check_eq("t4_dval", 32'(dval_m), 32'h1);

    // 5: accept and refill on the same edge
    do_reset();
    data_ready = 1'b0;
    send_word(4'hF);
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    data_ready = 1'b1;
    drive(1'b0, 1'b1, 1'b0);
    check_eq("t5_dout", 32'(dout_m), 32'h6);
    check_eq("t5_dval", 32'(dval_m), 32'h1);
    check_eq("t5_ovr",  32'(ovr_m),  32'h0);

    // 6: async reset mid-word with a word pending, then a fresh word
    data_ready = 1'b0;
    send_word(4'hF);
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    #2;
    do_reset();
    send_word(4'h9);
    check_eq("t6_dout", 32'(dout_m), 32'h9);
    check_eq("t6_dval", 32'(dval_m), 32'h1);

    // randomized traffic against the model
    for (int n = 0; n < 4000; n++) begin
      serial_in  = 1'($urandom_range(0, 1));
      bit_valid  = ($urandom_range(0, 9) < 7);
      sof        = ($urandom_range(0, 19) == 0);
      data_ready = 1'($urandom_range(0, 1));
      clr_ovr    = ($urandom_range(0, 9) == 0);
      tick();
      if ($urandom_range(0, 599) == 0) begin
        #2;
        do_reset();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sipo_deser.md
Name: sipo_deser

Overview:
- Downstream consumer of the piso serializer: samples the 1-bit serial stream and reassembles it into WIDTH-bit parallel words.
- Presents each completed word on a valid/ready output handshake to the next stage.
- A 1-deep holding register decouples shifting from consumption; loss of a word is flagged by a sticky overrun bit.
- Frame realignment is via a start-of-frame strobe.

Parameters:
- WIDTH, 4, word width in bits; legal range 2..32.
- MSB_FIRST, 1, 1 = first received bit lands in data_out[WIDTH-1] (matches piso shift order); 0 = first bit lands in data_out[0].

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- serial_in  input  1  serial data bit from piso data_out.
- bit_valid  input  1  serial_in carries a valid bit this cycle.
- sof  input  1  start of frame; realigns the bit counter.
- data_ready  input  1  downstream accepts data_out this cycle.
- clr_ovr  input  1  synchronous clear of the overrun flag.
- data_out  output  WIDTH  assembled word (holding register).
- data_valid  output  1  data_out holds an unconsumed word.
- overrun  output  1  sticky: a completed word was dropped.
- bit_cnt  output  $clog2(WIDTH)  bits collected in the current partial word.

Behaviour:
- Reset (rst=0, async): shift register, data_out, bit_cnt all 0; data_valid=0; overrun=0. Reset has priority over everything; a partial word is discarded.
- Shift, on each posedge with bit_valid=1:
  - MSB_FIRST=1: sreg <= {sreg[WIDTH-2:0], serial_in}.
  - MSB_FIRST=0: sreg <= {serial_in, sreg[WIDTH-1:1]}.
  - bit_cnt increments.
- No shift and bit_cnt unchanged when bit_valid=0 (unless sof=1).
- sof=1 with bit_valid=1: the sampled bit is bit 0 of a new word. Prior partial content is discarded and bit_cnt becomes 1.
- sof=1 with bit_valid=0: bit_cnt <= 0; partial content discarded. Neither case affects data_out or data_valid.
- Word complete = bit_valid=1 and bit_cnt==WIDTH-1 (or WIDTH==1 equivalent after sof; not legal). On that edge:
  - bit_cnt wraps to 0.
  - The full word (including the current bit) is the completion candidate.
- Completion candidate handling, evaluated on the same edge as completion:
  - data_valid=0 → data_out <= word, data_valid <= 1.
  - data_valid=1 and data_ready=1 → data_out <= word, data_valid stays 1 (back-to-back accept and refill).
  - data_valid=1 and data_ready=0 → word dropped, data_out unchanged, overrun <= 1.
- Latency: data_valid rises on the same clock edge that samples the WIDTH-th bit, so it is visible in the following cycle. Zero added cycles.
- Handshake:
  - Transfer occurs on any edge with data_valid=1 and data_ready=1.
  - Without a simultaneous completion, data_valid <= 0 and data_out holds its value.
  - data_out must be stable while data_valid=1 and data_ready=0.
  - data_ready while data_valid=0 is ignored.
- overrun is sticky. clr_ovr=1 clears it, except that an overrun event on the same edge wins and overrun stays 1.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package: bit-order constants (MSB_FIRST/LSB_FIRST) and a WIDTH-derived counter-width function or constant shared with piso.
- Natural sub-module: sipo_shift_core, containing the shift register and bit counter with sof alignment. It emits word and word_done.
- The top level holds the output register, the valid/ready handshake, and overrun logic.

Test Plan:
1. Reset, then bits 1,1,1,1 with bit_valid=1 and data_ready=1 → data_valid pulses 1 cycle after the 4th bit edge; data_out=4'hF; overrun=0.
2. Bits 0,1,0,1 (MSB first) → data_out=4'h5. Same stream with MSB_FIRST=0 → data_out=4'hA.
3. data_ready=0, send 4'h5 then 4'h3 → data_out stays 4'h5, data_valid=1, overrun=1 after the 8th bit. Then clr_ovr=1 → overrun=0.
4. Send 1,0 then sof with bit 1, followed by 1,0,0 → discards the partial; data_out=4'hC. bit_cnt reads 1 after the sof edge.
5. data_valid=1 holding 4'hF, data_ready=1 on the same edge the next word 4'h6 completes → data_out=4'h6, data_valid stays 1, no overrun.
6. Pull rst low mid-word (after 2 bits) with data_valid=1 → all outputs 0 immediately (async). After release, a fresh 4-bit word 4'h9 assembles correctly.
